// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   ifu_state_e  fetch FSM state (IDLE/ADDR/RWAIT/HOLD), 2-bit
//   RESP_OKAY    the only read response that is not a fault
//   DEF_RESET_PC default value of the PC capture register after reset
package ifu_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, RWAIT, HOLD} ifu_state_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: fetches one instruction per accepted PC over an AXI-lite-style read channel.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEF_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  pc_valid_i,
  output logic                  pc_ready_o,
  input  logic                  flush_i,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic                  inst_fault_o,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i
);
  ifu_state_e state, state_n;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] inst_q;
  logic fault_q, drop_q, misaligned, dropping;
  assign misaligned = pc_i[1:0] != 2'b00;
  assign dropping = drop_q | flush_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = pc_valid_i ? (misaligned ? HOLD : ADDR) : IDLE;
      ADDR:    state_n = arready_i ? RWAIT : ADDR;
      RWAIT:   state_n = rvalid_i ? (dropping ? IDLE : HOLD) : RWAIT;
      HOLD:    state_n = (inst_ready_i | flush_i) ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      fault_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      if (state == IDLE && pc_valid_i) begin
        pc_q    <= pc_i;
        inst_q  <= '0;
        fault_q <= misaligned;
      end
      if (state == RWAIT && rvalid_i && !dropping) begin
        inst_q  <= rdata_i;
        fault_q <= rresp_i != RESP_OKAY;
      end
      drop_q <= (state == ADDR || (state == RWAIT && !rvalid_i)) && dropping;
    end
  assign pc_ready_o   = state == IDLE;
  assign arvalid_o    = state == ADDR;
  assign rready_o     = state == RWAIT;
  assign inst_valid_o = state == HOLD;
  assign araddr_o     = pc_q;
  assign inst_pc_o    = pc_q;
  assign inst_o       = inst_q;
  assign inst_fault_o = fault_q;
`ifdef IFU_TRACE_EN
  logic [31:0] stall_q;
  function int ifu_stall_cycles();
    return int'(stall_q);
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_q <= '0;
    else if (state == RWAIT && !rvalid_i) stall_q <= stall_q + 32'd1;
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: self-checking bench for ifu_fetch (directed scenarios plus randomized transactions).
module tb_ifu_fetch;
  import ifu_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] pc_i = '0, araddr_o, rdata_i = '0, inst_o, inst_pc_o;
  logic pc_valid_i = 1'b0, pc_ready_o, flush_i = 1'b0, arvalid_o, arready_i = 1'b0;
  logic [1:0] rresp_i = 2'b00;
  logic rvalid_i = 1'b0, rready_o, inst_fault_o, inst_valid_o, inst_ready_i = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
    .flush_i(flush_i), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_fault_o(inst_fault_o),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (pc_ready_o !== 1'b1 || arvalid_o !== 1'b0 || rready_o !== 1'b0) begin errors++; $display("FAIL reset_ctrl got pc_ready=%b arvalid=%b rready=%b exp 1 0 0", pc_ready_o, arvalid_o, rready_o); end
    checks++; if (inst_valid_o !== 1'b0 || inst_fault_o !== 1'b0) begin errors++; $display("FAIL reset_inst_flags got valid=%b fault=%b exp 0 0", inst_valid_o, inst_fault_o); end
    checks++; if (inst_o !== 32'h0 || inst_pc_o !== 32'h8000_0000 || araddr_o !== 32'h8000_0000) begin errors++; $display("FAIL reset_regs got inst=%h pc=%h araddr=%h exp 0 80000000 80000000", inst_o, inst_pc_o, araddr_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_wait();
    pc_i = 32'h8000_0000; pc_valid_i = 1'b1; inst_ready_i = 1'b1;
    checks++; if (pc_ready_o !== 1'b1 || arvalid_o !== 1'b0) begin errors++; $display("FAIL zw_c0 got pc_ready=%b arvalid=%b exp 1 0", pc_ready_o, arvalid_o); end
    @(negedge clk);
    pc_valid_i = 1'b0; arready_i = 1'b1;
    checks++; if (arvalid_o !== 1'b1 || araddr_o !== 32'h8000_0000 || pc_ready_o !== 1'b0) begin errors++; $display("FAIL zw_c1 got arvalid=%b araddr=%h pc_ready=%b exp 1 80000000 0", arvalid_o, araddr_o, pc_ready_o); end
    @(negedge clk);
    arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h0000_0413; rresp_i = RESP_OKAY;
    checks++; if (rready_o !== 1'b1 || arvalid_o !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL zw_c2 got rready=%b arvalid=%b valid=%b exp 1 0 0", rready_o, arvalid_o, inst_valid_o); end
    @(negedge clk);
    rvalid_i = 1'b0; rdata_i = 32'hffff_ffff;
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0413 || inst_pc_o !== 32'h8000_0000 || inst_fault_o !== 1'b0) begin errors++; $display("FAIL zw_c3 got valid=%b inst=%h pc=%h fault=%b exp 1 00000413 80000000 0", inst_valid_o, inst_o, inst_pc_o, inst_fault_o); end
    @(negedge clk);
    inst_ready_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b0 || pc_ready_o !== 1'b1) begin errors++; $display("FAIL zw_c4 got valid=%b pc_ready=%b exp 0 1", inst_valid_o, pc_ready_o); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    int hs;
    d = $urandom; hs = 0;
    pc_i = 32'h8000_0040; pc_valid_i = 1'b1;
    @(negedge clk);
    pc_valid_i = 1'b0; pc_i = $urandom;
    for (int k = 0; k < 4; k++) begin
      checks++; if (arvalid_o !== 1'b1 || araddr_o !== 32'h8000_0040) begin errors++; $display("FAIL bp_addr_stable k=%0d got arvalid=%b araddr=%h exp 1 80000040", k, arvalid_o, araddr_o); end
      arready_i = (k == 3);
      @(negedge clk);
    end
    arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = d; rresp_i = RESP_OKAY;
    @(negedge clk);
    rvalid_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++; if (inst_valid_o !== 1'b1 || inst_o !== d || inst_pc_o !== 32'h8000_0040 || inst_fault_o !== 1'b0) begin errors++; $display("FAIL bp_hold k=%0d got valid=%b inst=%h pc=%h fault=%b exp 1 %h 80000040 0", k, inst_valid_o, inst_o, inst_pc_o, inst_fault_o, d); end
      inst_ready_i = (k == 5);
      if (inst_valid_o && inst_ready_i) hs++;
      @(negedge clk);
    end
    if (inst_valid_o && inst_ready_i) hs++;
    inst_ready_i = 1'b0;
    @(negedge clk);
    if (inst_valid_o && inst_ready_i) hs++;
    checks++; if (hs !== 1 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL bp_handshakes got %0d valid=%b exp 1 0", hs, inst_valid_o); end
  endtask

  task automatic test_bus_error();
    pc_i = 32'h8000_0010; pc_valid_i = 1'b1;
    @(negedge clk);
    pc_valid_i = 1'b0; arready_i = 1'b1;
    @(negedge clk);
    arready_i = 1'b0; rvalid_i = 1'b1; rresp_i = 2'b10; rdata_i = 32'h1234_5678;
    @(negedge clk);
    rvalid_i = 1'b0; rresp_i = RESP_OKAY;
    checks++; if (inst_valid_o !== 1'b1 || inst_fault_o !== 1'b1 || inst_pc_o !== 32'h8000_0010) begin errors++; $display("FAIL bus_error got valid=%b fault=%b pc=%h exp 1 1 80000010", inst_valid_o, inst_fault_o, inst_pc_o); end
    inst_ready_i = 1'b1;
    @(negedge clk);
    inst_ready_i = 1'b0;
  endtask

  task automatic test_misaligned();
    pc_i = 32'h8000_0002; pc_valid_i = 1'b1;
    @(negedge clk);
    pc_valid_i = 1'b0;
    checks++; if (arvalid_o !== 1'b0 || inst_valid_o !== 1'b1 || inst_fault_o !== 1'b1 || inst_o !== 32'h0 || inst_pc_o !== 32'h8000_0002) begin errors++; $display("FAIL misaligned got arvalid=%b valid=%b fault=%b inst=%h pc=%h exp 0 1 1 0 80000002", arvalid_o, inst_valid_o, inst_fault_o, inst_o, inst_pc_o); end
    inst_ready_i = 1'b1;
    @(negedge clk);
    inst_ready_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b0 || pc_ready_o !== 1'b1 || arvalid_o !== 1'b0) begin errors++; $display("FAIL misaligned_release got valid=%b pc_ready=%b arvalid=%b exp 0 1 0", inst_valid_o, pc_ready_o, arvalid_o); end
  endtask

  task automatic test_flush();
    pc_i = 32'h8000_0080; pc_valid_i = 1'b1;
    @(negedge clk);
    pc_valid_i = 1'b0; arready_i = 1'b1;
    @(negedge clk);
    arready_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'hdead_beef;
    checks++; if (rready_o !== 1'b1) begin errors++; $display("FAIL flush_rready got %b exp 1", rready_o); end
    @(negedge clk);
    rvalid_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b0 || pc_ready_o !== 1'b1) begin errors++; $display("FAIL flush_drop got valid=%b pc_ready=%b exp 0 1", inst_valid_o, pc_ready_o); end
    pc_i = 32'h8000_0100; pc_valid_i = 1'b1;
    @(negedge clk);
    pc_valid_i = 1'b0; arready_i = 1'b1;
    @(negedge clk);
    arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h0010_0093;
    @(negedge clk);
    rvalid_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0010_0093 || inst_pc_o !== 32'h8000_0100 || inst_fault_o !== 1'b0) begin errors++; $display("FAIL flush_next got valid=%b inst=%h pc=%h fault=%b exp 1 00100093 80000100 0", inst_valid_o, inst_o, inst_pc_o, inst_fault_o); end
    inst_ready_i = 1'b1;
    @(negedge clk);
    inst_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    pc_i = 32'h8000_0200; pc_valid_i = 1'b1;
    @(negedge clk);
    pc_valid_i = 1'b0; arready_i = 1'b1;
    @(negedge clk);
    arready_i = 1'b0;
    checks++; if (rready_o !== 1'b1) begin errors++; $display("FAIL rmid_in_rwait got rready=%b exp 1", rready_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rready_o !== 1'b0 || arvalid_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_fault_o !== 1'b0 || pc_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_async_ctrl got rready=%b arvalid=%b valid=%b fault=%b pc_ready=%b exp 0 0 0 0 1", rready_o, arvalid_o, inst_valid_o, inst_fault_o, pc_ready_o); end
    checks++; if (inst_o !== 32'h0 || inst_pc_o !== 32'h8000_0000 || araddr_o !== 32'h8000_0000) begin errors++; $display("FAIL rmid_async_regs got inst=%h pc=%h araddr=%h exp 0 80000000 80000000", inst_o, inst_pc_o, araddr_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (pc_ready_o !== 1'b1 || inst_pc_o !== 32'h8000_0000 || rready_o !== 1'b0) begin errors++; $display("FAIL rmid_after got pc_ready=%b pc=%h rready=%b exp 1 80000000 0", pc_ready_o, inst_pc_o, rready_o); end
  endtask

  // Each transaction's expected outcome comes straight from the rules: a flush in
  // ADDR/RWAIT (or with the data beat) yields no instruction; otherwise the
  // instruction is pc plus returned data (zero if misaligned) with fault = misaligned
  // or non-OKAY response, held until decode accepts it or a flush drops it.
  task automatic test_random();
    logic [31:0] pc, data, exp_inst;
    logic [1:0] resp;
    logic mis, exp_fault;
    int fl, d, w;
    for (int n = 0; n < 60; n++) begin
      pc = $urandom & 32'hffff_fffc;
      mis = ($urandom_range(0, 5) == 0);
      if (mis) pc[1:0] = 2'($urandom_range(1, 3));
      data = $urandom;
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY;
      fl = $urandom_range(0, 7);
      if (fl > 4 || (mis && fl != 4)) fl = 0;
      exp_inst = mis ? 32'h0 : data;
      exp_fault = mis || (resp != RESP_OKAY);
      w = 0;
      while (!pc_ready_o && w < 20) begin @(negedge clk); w++; end
      checks++; if (pc_ready_o !== 1'b1) begin errors++; $display("FAIL rnd_idle n=%0d got pc_ready=%b exp 1", n, pc_ready_o); end
      pc_i = pc; pc_valid_i = 1'b1; flush_i = $urandom_range(0, 1);
      @(negedge clk);
      pc_valid_i = 1'b0; pc_i = $urandom; flush_i = 1'b0;
      if (mis) begin
        checks++; if (arvalid_o !== 1'b0) begin errors++; $display("FAIL rnd_mis_noaddr n=%0d got arvalid=%b exp 0", n, arvalid_o); end
      end else begin
        d = $urandom_range(0, 3);
        for (int k = 0; k <= d; k++) begin
          checks++; if (arvalid_o !== 1'b1 || araddr_o !== pc) begin errors++; $display("FAIL rnd_addr n=%0d k=%0d got arvalid=%b araddr=%h exp 1 %h", n, k, arvalid_o, araddr_o, pc); end
          flush_i = (fl == 1 && k == 0);
          arready_i = (k == d);
          @(negedge clk);
        end
        arready_i = 1'b0; flush_i = 1'b0;
        d = $urandom_range(0, 3);
        for (int k = 0; k <= d; k++) begin
          checks++; if (rready_o !== 1'b1 || arvalid_o !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL rnd_rwait n=%0d k=%0d got rready=%b arvalid=%b valid=%b exp 1 0 0", n, k, rready_o, arvalid_o, inst_valid_o); end
          rvalid_i = (k == d);
          rdata_i = (k == d) ? data : $urandom;
          rresp_i = (k == d) ? resp : 2'($urandom);
          flush_i = (fl == 2 && k == 0) || (fl == 3 && k == d);
          @(negedge clk);
        end
        rvalid_i = 1'b0; flush_i = 1'b0;
      end
      if (fl >= 1 && fl <= 3) begin
        checks++; if (inst_valid_o !== 1'b0 || pc_ready_o !== 1'b1) begin errors++; $display("FAIL rnd_dropped n=%0d got valid=%b pc_ready=%b exp 0 1", n, inst_valid_o, pc_ready_o); end
      end else begin
        d = $urandom_range(0, 4);
        for (int k = 0; k <= d; k++) begin
          checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== pc || inst_o !== exp_inst || inst_fault_o !== exp_fault) begin errors++; $display("FAIL rnd_inst n=%0d k=%0d got valid=%b pc=%h inst=%h fault=%b exp 1 %h %h %b", n, k, inst_valid_o, inst_pc_o, inst_o, inst_fault_o, pc, exp_inst, exp_fault); end
          inst_ready_i = (k == d) && (fl == 0 || $urandom_range(0, 1) == 1);
          flush_i = (k == d) && fl == 4;
          @(negedge clk);
        end
        inst_ready_i = 1'b0; flush_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b0 || pc_ready_o !== 1'b1) begin errors++; $display("FAIL rnd_release n=%0d got valid=%b pc_ready=%b exp 0 1", n, inst_valid_o, pc_ready_o); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_bus_error();
    test_misaligned();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
